// File: rtl/majority_vote.sv
// rtl/majority_vote.sv - registered 5-input majority voter with ones-count and valid flag
// One clock of latency; outputs hold their last valid result while in_valid is low.
module majority_vote #(
   parameter int THRESHOLD = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       x1,
   input  logic       x2,
   input  logic       x3,
   input  logic       x4,
   input  logic       x5,
   output logic       z1,
   output logic [2:0] count,
   output logic       out_valid
);

   localparam logic [2:0] LP_THRESHOLD = 3'(THRESHOLD);

   logic [2:0] w_popcount;
   logic       w_vote;
   logic       r_z1;
   logic [2:0] r_count;
   logic       r_out_valid;

   // Zero-extend each vote so the sum cannot wrap; maximum is 5.
   assign w_popcount = {2'b00, x1} + {2'b00, x2} + {2'b00, x3} + {2'b00, x4} + {2'b00, x5};
   assign w_vote     = (w_popcount >= LP_THRESHOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_z1        <= 1'b0;
         r_count     <= 3'd0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_z1    <= w_vote;
            r_count <= w_popcount;
         end
      end
   end

   assign z1        = r_z1;
   assign count     = r_count;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_majority_vote.sv
// tb/tb_majority_vote.sv - directed, table-driven bench for majority_vote
// Three instances share stimulus: default threshold 3, plus thresholds 5 and 1.
module tb_majority_vote;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [4:0] vec;
   logic       z1_t3, z1_t5, z1_t1;
   logic [2:0] count_t3, count_t5, count_t1;
   logic       ov_t3, ov_t5, ov_t1;

   int n_tests;
   int n_fail;

   majority_vote #(.THRESHOLD(3)) dut_t3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .x1(vec[4]), .x2(vec[3]), .x3(vec[2]), .x4(vec[1]), .x5(vec[0]),
      .z1(z1_t3), .count(count_t3), .out_valid(ov_t3)
   );

   majority_vote #(.THRESHOLD(5)) dut_t5 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .x1(vec[4]), .x2(vec[3]), .x3(vec[2]), .x4(vec[1]), .x5(vec[0]),
      .z1(z1_t5), .count(count_t5), .out_valid(ov_t5)
   );

   majority_vote #(.THRESHOLD(1)) dut_t1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .x1(vec[4]), .x2(vec[3]), .x3(vec[2]), .x4(vec[1]), .x5(vec[0]),
      .z1(z1_t1), .count(count_t1), .out_valid(ov_t1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] v;
      logic       z3;
      logic [2:0] c;
      logic       z5;
      logic       z1;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input int actual, input int expected);
      n_tests++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_all3(input string name, input int ez, input int ec, input int ev);
      check({name, ".z1"}, int'(z1_t3), ez);
      check({name, ".count"}, int'(count_t3), ec);
      check({name, ".out_valid"}, int'(ov_t3), ev);
   endtask

   task automatic step(input logic [4:0] v, input logic valid);
      vec      = v;
      in_valid = valid;
      @(posedge clk);
      #1;
   endtask

   int ones;
   int z_hits;

   initial begin
      n_tests = 0;
      n_fail  = 0;

      // Hand-computed: {vector, z1@T3, count, z1@T5, z1@T1}
      tbl[0] = '{5'b00000, 1'b0, 3'd0, 1'b0, 1'b0};
      tbl[1] = '{5'b10000, 1'b0, 3'd1, 1'b0, 1'b1};
      tbl[2] = '{5'b11100, 1'b1, 3'd3, 1'b0, 1'b1};
      tbl[3] = '{5'b11110, 1'b1, 3'd4, 1'b0, 1'b1};
      tbl[4] = '{5'b11111, 1'b1, 3'd5, 1'b1, 1'b1};
      tbl[5] = '{5'b00111, 1'b1, 3'd3, 1'b0, 1'b1};
      tbl[6] = '{5'b10101, 1'b1, 3'd3, 1'b0, 1'b1};
      tbl[7] = '{5'b00011, 1'b0, 3'd2, 1'b0, 1'b1};
      tbl[8] = '{5'b11000, 1'b0, 3'd2, 1'b0, 1'b1};

      // Reset held while clocking with all-ones valid input
      rst_n    = 1'b0;
      vec      = 5'b11111;
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all3("reset_hold", 0, 0, 0);
      check("reset_hold.t5_valid", int'(ov_t5), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_all3("reset_release", 1, 5, 1);
      check("reset_release.t5_z1", int'(z1_t5), 1);
      check("reset_release.t1_z1", int'(z1_t1), 1);

      // Boundary and representative vectors
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].v, 1'b1);
         check_all3($sformatf("tbl%0d", i), int'(tbl[i].z3), int'(tbl[i].c), 1);
         check($sformatf("tbl%0d.t5_z1", i), int'(z1_t5), int'(tbl[i].z5));
         check($sformatf("tbl%0d.t1_z1", i), int'(z1_t1), int'(tbl[i].z1));
      end

      // Exhaustive sweep, back-to-back, with an async reset pulse in the middle
      z_hits = 0;
      for (int i = 0; i < 32; i++) begin
         step(5'(i), 1'b1);
         ones = 0;
         for (int b = 0; b < 5; b++) if (((i >> b) & 1) == 1) ones++;
         check_all3($sformatf("sweep%0d", i), (ones >= 3) ? 1 : 0, ones, 1);
         check($sformatf("sweep%0d.t5_z1", i), int'(z1_t5), (ones == 5) ? 1 : 0);
         check($sformatf("sweep%0d.t1_z1", i), int'(z1_t1), (ones >= 1) ? 1 : 0);
         if (z1_t3) z_hits++;
         if (i == 15) begin
            #2;
            rst_n = 1'b0;
            #1;
            check_all3("async_reset_midcycle", 0, 0, 0);
            @(posedge clk);
            #1;
            check_all3("async_reset_edge", 0, 0, 0);
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      check("sweep.z1_count", z_hits, 16);

      // Hold behaviour with in_valid low
      step(5'b01110, 1'b1);
      check_all3("hold_load", 1, 3, 1);
      for (int k = 0; k < 3; k++) begin
         step(5'b00000, 1'b0);
         check_all3($sformatf("hold%0d", k), 1, 3, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
